nes_pad_reader: RTL and testbench
=================================

NES_PAD_READER -- requirements
Module: nes_pad_reader

Interface
REQ-001 SHALL have parameter LATCH_CYCLES, default 300, latch pulse width in clk cycles (12 us at 25 MHz).
REQ-002 SHALL have parameter PULSE_CYCLES, default 150, width of each pad_clk high phase and each low phase in clk cycles.
REQ-003 SHALL have parameter POLL_CYCLES, default 416667, clk cycles from one poll start to the next (about 60 Hz).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 pad_data  input  1  serial data from controller; low = button pressed; asynchronous to clk.
REQ-008 pad_latch  output  1  latch strobe to controller; active-high.
REQ-009 pad_clk  output  1  shift clock to controller; idles low.
REQ-010 buttons  output  8  pressed flags, active-high: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
REQ-011 dpad_input  output  4  ordered {right, up, down, left}: [0]=Left, [1]=Down, [2]=Up, [3]=Right; active-high.
REQ-012 frame_valid  output  1  one-cycle pulse when buttons and dpad_input update.

Function
REQ-013 SHALL pass pad_data through a 2-flop synchronizer before any use; all sampling SHALL use the synchronized value.
REQ-014 SHALL implement states IDLE, LATCH, SAMPLE, CLK_HIGH, CLK_LOW, DONE.
REQ-015 IDLE: free-running poll counter; on reaching POLL_CYCLES-1, SHALL clear it and enter LATCH. The poll counter SHALL run in all states, so the poll period is independent of read duration.
REQ-016 LATCH: pad_latch=1 for exactly LATCH_CYCLES cycles; bit index cleared to 0; then enter SAMPLE.
REQ-017 SAMPLE: lasts one cycle; SHALL store the inverted synchronized pad_data into shift bit [index]. If index==7, enter DONE; otherwise enter CLK_HIGH.
REQ-018 CLK_HIGH: pad_clk=1 for PULSE_CYCLES cycles; then enter CLK_LOW and increment index.
REQ-019 CLK_LOW: pad_clk=0 for PULSE_CYCLES cycles; then enter SAMPLE.
REQ-020 A full read SHALL produce exactly 7 pad_clk rising edges and 8 samples, taken in the order A, B, Select, Start, Up, Down, Left, Right.
REQ-021 DONE: lasts one cycle; SHALL copy the shift register to buttons, set dpad_input = {buttons[7], buttons[4], buttons[5], buttons[6]} from the new value, pulse frame_valid=1 for that cycle, and return to IDLE.
REQ-022 buttons and dpad_input SHALL hold their value between DONE cycles; a partial read SHALL never be visible on them.
REQ-023 pad_latch and pad_clk SHALL be driven directly from registers and SHALL never be high in the same cycle.
REQ-024 Opposing directions SHALL be passed through unfiltered (Up and Down may both be 1).
REQ-025 An unplugged controller (pad_data pulled high) SHALL read as all zeros; pad_data stuck low SHALL read as 8'hFF. No error flag is raised.
REQ-026 Counters SHALL be sized to hold their maximum parameter value; the bit index SHALL be 3 bits and SHALL never exceed 7.

Reset
REQ-027 While reset_n=0: state=IDLE, all counters=0, synchronizer flops=1, pad_latch=0, pad_clk=0, buttons=8'h00, dpad_input=4'h0, frame_valid=0.
REQ-028 Reset asserted mid-read SHALL abort the read immediately; no frame_valid pulse and no buttons update SHALL occur for that read.
REQ-029 After reset_n rises, the first LATCH SHALL begin POLL_CYCLES cycles later.

Verification (bench params LATCH_CYCLES=4, PULSE_CYCLES=2, POLL_CYCLES=100)
REQ-030 Pad model returning pressed pattern 8'b0001_0000 (Up only) -> after DONE, buttons=8'h10, dpad_input=4'b0100, frame_valid high for 1 cycle.
REQ-031 Right+Left pressed (8'hC0) -> buttons=8'hC0, dpad_input=4'b1001; pad_clk shows exactly 7 high pulses of 2 cycles each, and pad_latch is high for exactly 4 cycles.
REQ-032 pad_data held high -> buttons=8'h00 and dpad_input=0 every frame; frame_valid pulses are spaced exactly 100 cycles apart.
REQ-033 Press A on frame 1, release it on frame 2 -> buttons=8'h01 after frame 1 and 8'h00 after frame 2; outputs are stable between pulses.
REQ-034 reset_n driven low during the 3rd CLK_HIGH -> pad_clk=0 and pad_latch=0 immediately, buttons=0, no frame_valid; the next latch starts 100 cycles after reset_n rises.
REQ-035 Across all tests, assertions SHALL check: pad_latch and pad_clk never high together, and frame_valid never high on two consecutive cycles.

Source files
------------

// File: rtl/nes_pad_reader.sv
// NES controller poller: latches the pad, clocks out 8 serial bits and publishes
// a debounced-by-frame button snapshot with a one-cycle frame_valid strobe.
module nes_pad_reader #(
   parameter int LATCH_CYCLES = 300,
   parameter int PULSE_CYCLES = 150,
   parameter int POLL_CYCLES  = 416667
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pad_data,
   output logic       pad_latch,
   output logic       pad_clk,
   output logic [7:0] buttons,
   output logic [3:0] dpad_input,
   output logic       frame_valid
);

   localparam int PH_MAX = (LATCH_CYCLES > PULSE_CYCLES) ? LATCH_CYCLES : PULSE_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int POLL_W = $clog2(POLL_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, LATCH, SAMPLE, CLK_HIGH, CLK_LOW, DONE} state_t;

   state_t            state_q, state_d;
   logic [POLL_W-1:0] poll_q, poll_d;
   logic [PH_W-1:0]   ph_q, ph_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        shift_q, shift_d;
   logic [1:0]        sync_q, sync_d;
   logic [7:0]        buttons_q, buttons_d;
   logic [3:0]        dpad_q, dpad_d;
   logic              fv_q, fv_d;
   logic              pad_latch_q, pad_latch_d;
   logic              pad_clk_q, pad_clk_d;

   logic poll_wrap, latch_end, pulse_end;

   assign poll_wrap = (poll_q == POLL_W'(POLL_CYCLES - 1));
   assign latch_end = (ph_q == PH_W'(LATCH_CYCLES - 1));
   assign pulse_end = (ph_q == PH_W'(PULSE_CYCLES - 1));

   // Synchronizer resets to 1 so a reset looks like "nothing pressed".
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         poll_q      <= '0;
         ph_q        <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         sync_q      <= 2'b11;
         buttons_q   <= '0;
         dpad_q      <= '0;
         fv_q        <= 1'b0;
         pad_latch_q <= 1'b0;
         pad_clk_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         poll_q      <= poll_d;
         ph_q        <= ph_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         sync_q      <= sync_d;
         buttons_q   <= buttons_d;
         dpad_q      <= dpad_d;
         fv_q        <= fv_d;
         pad_latch_q <= pad_latch_d;
         pad_clk_q   <= pad_clk_d;
      end
   end

   always_comb begin
      state_d = state_q;
      poll_d  = poll_wrap ? '0 : poll_q + POLL_W'(1);
      ph_d    = ph_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      sync_d  = {sync_q[0], pad_data};
      case (state_q)
         IDLE: begin
            if (poll_wrap) begin
               state_d = LATCH;
               ph_d    = '0;
               idx_d   = '0;
            end
         end
         LATCH: begin
            idx_d = '0;
            if (latch_end) begin
               state_d = SAMPLE;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         SAMPLE: begin
            shift_d[idx_q] = ~sync_q[1];
            ph_d           = '0;
            state_d        = (idx_q == 3'd7) ? DONE : CLK_HIGH;
         end
         CLK_HIGH: begin
            if (pulse_end) begin
               state_d = CLK_LOW;
               ph_d    = '0;
               idx_d   = idx_q + 3'd1;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         CLK_LOW: begin
            if (pulse_end) begin
               state_d = SAMPLE;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes are registered off the next state so they line up with the state they mark.
   always_comb begin
      pad_latch_d = (state_d == LATCH);
      pad_clk_d   = (state_d == CLK_HIGH);
      fv_d        = (state_q == DONE);
      buttons_d   = buttons_q;
      dpad_d      = dpad_q;
      if (state_q == DONE) begin
         buttons_d = shift_q;
         dpad_d    = {shift_q[7], shift_q[4], shift_q[5], shift_q[6]};
      end
   end

   assign pad_latch   = pad_latch_q;
   assign pad_clk     = pad_clk_q;
   assign buttons     = buttons_q;
   assign dpad_input  = dpad_q;
   assign frame_valid = fv_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: behavioural pad shift register, frame scoreboard and
// per-cycle protocol monitor.
module tb_nes_pad_reader;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       pad_data;
   logic       pad_latch, pad_clk, frame_valid;
   logic [7:0] buttons;
   logic [3:0] dpad_input;

   int checks = 0;
   int failures = 0;

   nes_pad_reader #(.LATCH_CYCLES(4), .PULSE_CYCLES(2), .POLL_CYCLES(100)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pad_data   (pad_data),
      .pad_latch  (pad_latch),
      .pad_clk    (pad_clk),
      .buttons    (buttons),
      .dpad_input (dpad_input),
      .frame_valid(frame_valid)
   );

   always #5 clk = ~clk;

   // Pad model: 4021-style shift register, active-low, ones shifted in.
   logic [7:0] pressed = 8'h00;
   logic [7:0] sh = 8'hFF;
   always @(posedge pad_latch or posedge pad_clk) begin
      if (pad_latch) sh = ~pressed;
      else           sh = {1'b1, sh[7:1]};
   end
   assign pad_data = sh[0];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   logic [11:0] sb[$];

   // Monitor
   int         cyc = 0;
   int         last_fv = -1;
   int         latch_w = 0, clk_w = 0, clk_pulses = 0;
   logic       fv_prev = 1'b0, latch_prev = 1'b0, clk_prev = 1'b0;
   logic [11:0] hold = '0;
   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         last_fv = -1; latch_w = 0; clk_w = 0; clk_pulses = 0;
         fv_prev = 1'b0; latch_prev = 1'b0; clk_prev = 1'b0; hold = '0;
      end else begin
         chk("latch_clk_overlap", {31'd0, pad_latch & pad_clk}, 32'd0);
         if (pad_latch) latch_w++;
         if (pad_clk) clk_w++;
         if (latch_prev && !pad_latch) begin
            chk("latch_width", latch_w, 4);
            latch_w = 0;
         end
         if (clk_prev && !pad_clk) begin
            chk("pad_clk_width", clk_w, 2);
            clk_w = 0;
            clk_pulses++;
         end
         if (frame_valid) begin
            chk("fv_consecutive", {31'd0, fv_prev}, 32'd0);
            chk("pad_clk_pulses", clk_pulses, 7);
            clk_pulses = 0;
            if (last_fv >= 0) chk("fv_spacing", cyc - last_fv, 100);
            last_fv = cyc;
            if (sb.size() == 0) begin
               chk("unexpected_frame", {20'd0, buttons, dpad_input}, 32'hFFFF_FFFF);
            end else begin
               logic [11:0] e;
               e = sb.pop_front();
               chk("buttons", buttons, e[11:4]);
               chk("dpad_input", dpad_input, e[3:0]);
            end
            hold = {buttons, dpad_input};
         end else begin
            chk("hold_stable", {buttons, dpad_input}, hold);
         end
         fv_prev = frame_valid;
         latch_prev = pad_latch;
         clk_prev = pad_clk;
      end
   end

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("frame_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic run_frame(input logic [7:0] p, input logic [7:0] eb, input logic [3:0] ed);
      pressed = p;
      sb.push_back({eb, ed});
      wait_drain();
   endtask

   // Release reset on a falling edge and count rising edges until the latch appears.
   task automatic release_and_time_latch();
      int n = 0;
      @(negedge clk);
      reset_n = 1'b1;
      while (n < 300) begin
         @(posedge clk);
         #1;
         n++;
         if (pad_latch) break;
      end
      chk("first_latch_delay", n, 100);
   endtask

   initial begin
      int r, n;
      logic pc_prev;
      reset_n = 1'b0;
      pressed = 8'h10;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pad_latch", pad_latch, 0);
      chk("rst_pad_clk", pad_clk, 0);
      chk("rst_buttons", buttons, 0);
      chk("rst_dpad", dpad_input, 0);
      chk("rst_frame_valid", frame_valid, 0);

      release_and_time_latch();
      sb.push_back({8'h10, 4'b0100});
      wait_drain();
      run_frame(8'hC0, 8'hC0, 4'b1001);
      run_frame(8'h00, 8'h00, 4'b0000);
      run_frame(8'h00, 8'h00, 4'b0000);
      run_frame(8'h00, 8'h00, 4'b0000);
      run_frame(8'h01, 8'h01, 4'b0000);
      run_frame(8'h00, 8'h00, 4'b0000);
      run_frame(8'hFF, 8'hFF, 4'b1111);
      run_frame(8'h3C, 8'h3C, 4'b0110);

      // Abort a read during the third pad_clk high phase.
      pressed = 8'h81;
      r = 0; n = 0; pc_prev = 1'b0;
      while (r < 3 && n < 400) begin
         @(posedge clk);
         #1;
         if (pad_clk && !pc_prev) r++;
         pc_prev = pad_clk;
         n++;
      end
      chk("third_clk_seen", r, 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_pad_clk", pad_clk, 0);
      chk("abort_pad_latch", pad_latch, 0);
      chk("abort_buttons", buttons, 0);
      chk("abort_dpad", dpad_input, 0);
      chk("abort_frame_valid", frame_valid, 0);
      repeat (3) @(negedge clk);
      chk("abort_no_fv", frame_valid, 0);
      release_and_time_latch();
      sb.push_back({8'h81, 4'b1000});
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
